// File: rtl/gpr_pkg.sv
// Shared register-file constants: width, depth, address width and the hard-wired x0 address.
package gpr_pkg;

  localparam int unsigned GPR_XLEN = 32;
  localparam int unsigned GPR_NUM  = 32;
  localparam int unsigned GPR_AW   = $clog2(GPR_NUM);

  localparam logic [GPR_AW-1:0] GPR_X0 = '0;

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// Write-back bus between the GPR write-back sources and the register file write port.
interface gpr_wb_arbiter_if
  import gpr_pkg::*;
#(
  parameter int unsigned XLEN = GPR_XLEN,
  parameter int unsigned NUM  = GPR_NUM,
  parameter int unsigned NREQ = 3
);

  localparam int unsigned AW = $clog2(NUM);
  localparam int unsigned IW = $clog2(NREQ);

  logic                 hold;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic [AW-1:0]        gpr_addr_w;
  logic [XLEN-1:0]      gpr_data_w;
  logic [IW-1:0]        wb_id;
  logic                 wb_valid;

  modport master (
    output hold, req_valid, req_addr, req_data,
    input  req_ready, gpr_addr_w, gpr_data_w, wb_id, wb_valid
  );

  modport slave (
    input  hold, req_valid, req_addr, req_data,
    output req_ready, gpr_addr_w, gpr_data_w, wb_id, wb_valid
  );

endinterface

// File: rtl/gpr_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ = 3
) (
  input  logic [NREQ-1:0]          req,
  input  logic [$clog2(NREQ)-1:0]  ptr,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  idx,
  output logic                     any
);

  localparam int unsigned IW = $clog2(NREQ);

  // Scan NREQ positions starting at ptr; the first hit wins.
  always_comb begin
    int unsigned c;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      c = 32'(ptr) + off;
      if (c >= NREQ) c = c - NREQ;
      if (!any && req[IW'(c)]) begin
        any         = 1'b1;
        gnt[IW'(c)] = 1'b1;
        idx         = IW'(c);
      end
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// GPR write-port arbiter: round-robin grant of one write per cycle, x0 writes dropped
// immediately, winner registered onto the register-file port one cycle after accept.
module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int unsigned XLEN = GPR_XLEN,
  parameter int unsigned NUM  = GPR_NUM,
  parameter int unsigned NREQ = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  gpr_wb_arbiter_if.slave  bus
);

  localparam int unsigned AW = $clog2(NUM);
  localparam int unsigned IW = $clog2(NREQ);

  logic [AW-1:0]   addr_a [NREQ];
  logic [XLEN-1:0] data_a [NREQ];
  logic [NREQ-1:0] is_x0;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   win;
  logic            any;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   ptr_nxt;

  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] data_q;
  logic [IW-1:0]   id_q;
  logic            valid_q;

  // Unpack the flat request buses and classify each requester.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      addr_a[i]   = bus.req_addr[i*AW +: AW];
      data_a[i]   = bus.req_data[i*XLEN +: XLEN];
      is_x0[i]    = (addr_a[i] == AW'(GPR_X0));
      eligible[i] = bus.req_valid[i] && !is_x0[i] && !bus.hold;
    end
  end

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req (eligible),
    .ptr (ptr),
    .gnt (gnt),
    .idx (win),
    .any (any)
  );

  // x0 writes are acknowledged regardless of hold or arbitration.
  assign bus.req_ready = gnt | (bus.req_valid & is_x0);

  always_comb begin
    ptr_nxt = win + IW'(1);
    if (32'(win) == NREQ - 1) ptr_nxt = '0;
  end

  // Pointer and output port registers; address 0 means no write this cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
    end else if (any) begin
      ptr     <= ptr_nxt;
      addr_q  <= addr_a[win];
      data_q  <= data_a[win];
      id_q    <= win;
      valid_q <= 1'b1;
    end else begin
      addr_q  <= '0;
      valid_q <= 1'b0;
    end
  end

  assign bus.gpr_addr_w = addr_q;
  assign bus.gpr_data_w = data_q;
  assign bus.wb_id      = id_q;
  assign bus.wb_valid   = valid_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Bench for gpr_wb_arbiter: directed scenarios then randomized traffic against a
// round-robin reference model with fairness tracking.
module tb_gpr_wb_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NUM  = 32;
  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = $clog2(NUM);

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  gpr_wb_arbiter_if #(.XLEN(XLEN), .NUM(NUM), .NREQ(NREQ)) bus ();

  gpr_wb_arbiter #(.XLEN(XLEN), .NUM(NUM), .NREQ(NREQ)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester-side stimulus state
  logic            v [NREQ];
  logic [AW-1:0]   a [NREQ];
  logic [XLEN-1:0] d [NREQ];
  logic            h;

  // Reference model of the write port
  int              m_ptr;
  logic [AW-1:0]   m_addr;
  logic [XLEN-1:0] m_data;
  int              m_id;
  logic            m_valid;
  int              waits [NREQ];
  logic [NREQ-1:0] seen_ready;

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]               = v[i];
      bus.req_addr[i*AW +: AW]       = a[i];
      bus.req_data[i*XLEN +: XLEN]   = d[i];
    end
    bus.hold = h;
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_addr  = '0;
    m_data  = '0;
    m_id    = 0;
    m_valid = 1'b0;
  endtask

  function automatic int pick();
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (v[j] && a[j] != 0 && !h) return j;
    end
    return -1;
  endfunction

  // One clock cycle: check ready mid-cycle, advance the model at the edge, check the port after.
  task automatic step(input bit fair);
    int w;
    logic [NREQ-1:0] exp_rdy;
    #3;
    w = pick();
    exp_rdy = '0;
    for (int i = 0; i < NREQ; i++)
      if (v[i] && a[i] == 0) exp_rdy[i] = 1'b1;
    if (w >= 0) exp_rdy[w] = 1'b1;
    seen_ready = bus.req_ready;
    check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    if (fair) begin
      for (int i = 0; i < NREQ; i++) begin
        if (v[i] && a[i] != 0 && !h) begin
          if (bus.req_ready[i]) begin
            check("fair_wait", 64'(waits[i] < NREQ), 64'(1));
            waits[i] = 0;
          end else begin
            waits[i]++;
          end
        end
      end
    end
    @(posedge clock);
    if (w >= 0) begin
      m_addr  = a[w];
      m_data  = d[w];
      m_id    = w;
      m_valid = 1'b1;
      m_ptr   = (w + 1) % NREQ;
    end else begin
      m_addr  = '0;
      m_valid = 1'b0;
    end
    #1;
    check("gpr_addr_w", 64'(bus.gpr_addr_w), 64'(m_addr));
    check("gpr_data_w", 64'(bus.gpr_data_w), 64'(m_data));
    check("wb_id",      64'(bus.wb_id),      64'(m_id));
    check("wb_valid",   64'(bus.wb_valid),   64'(m_valid));
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1'b0;
      a[i] = '0;
      d[i] = '0;
    end
    h = 1'b0;
    drive();
  endtask

  initial begin
    reset_n = 1'b0;
    clear_reqs();
    model_reset();
    seen_ready = '0;
    for (int i = 0; i < NREQ; i++) waits[i] = 0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    check("rst_addr",  64'(bus.gpr_addr_w), 64'(0));
    check("rst_data",  64'(bus.gpr_data_w), 64'(0));
    check("rst_id",    64'(bus.wb_id),      64'(0));
    check("rst_valid", 64'(bus.wb_valid),   64'(0));

    // Single write from requester 0
    v[0] = 1'b1; a[0] = AW'(5); d[0] = 32'hDEAD_BEEF;
    drive();
    step(0);
    check("single_addr", 64'(bus.gpr_addr_w), 64'(5));
    check("single_data", 64'(bus.gpr_data_w), 64'h0000_0000_DEAD_BEEF);
    clear_reqs();

    // Asynchronous reset while a write is on the port
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_addr",  64'(bus.gpr_addr_w), 64'(0));
    check("async_rst_valid", 64'(bus.wb_valid),   64'(0));
    check("async_rst_data",  64'(bus.gpr_data_w), 64'(0));
    check("async_rst_id",    64'(bus.wb_id),      64'(0));
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Round-robin with all three continuously valid
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1'b1; a[i] = AW'(i + 1); d[i] = $urandom;
    end
    drive();
    for (int k = 0; k < 6; k++) begin
      step(0);
      check("rr_id",   64'(bus.wb_id),      64'(k % 3));
      check("rr_addr", 64'(bus.gpr_addr_w), 64'((k % 3) + 1));
    end

    // x0 drop alongside a real grant
    v[0] = 1'b0; v[1] = 1'b1; a[1] = '0; v[2] = 1'b1; a[2] = AW'(7);
    drive();
    step(0);
    check("x0_ready", 64'(seen_ready), 64'(3'b110));
    check("x0_addr",  64'(bus.gpr_addr_w), 64'(7));
    check("x0_id",    64'(bus.wb_id), 64'(2));

    // Hold for three cycles, then resume at the stored pointer
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1'b1; a[i] = AW'(i + 4); d[i] = $urandom;
    end
    h = 1'b1;
    drive();
    repeat (3) begin
      step(0);
      check("hold_ready", 64'(seen_ready), 64'(0));
    end
    h = 1'b0;
    drive();
    step(0);
    check("resume_id", 64'(bus.wb_id), 64'(0));

    // x0 drop is still acknowledged under hold
    clear_reqs();
    v[0] = 1'b1; h = 1'b1;
    drive();
    step(0);
    check("hold_x0_ready", 64'(seen_ready), 64'(3'b001));
    clear_reqs();
    step(0);

    // Randomized traffic; requesters keep a request stable until it is accepted
    seen_ready = '0;
    for (int i = 0; i < NREQ; i++) waits[i] = 0;
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] || seen_ready[i]) begin
          v[i] = ($urandom_range(0, 3) != 0);
          a[i] = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, NUM - 1));
          d[i] = $urandom;
        end
      end
      h = ($urandom_range(0, 7) == 0);
      drive();
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
